// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single memory port between a CPU and an external
//               requester, one transaction at a time, with alternating priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [1:0]            i_cpu_store_type,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_gnt,
    output logic                  o_cpu_rvalid,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    input  logic                  i_ext_req,
    input  logic                  i_ext_we,
    input  logic [1:0]            i_ext_store_type,
    input  logic [ADDR_WIDTH-1:0] i_ext_addr,
    input  logic [DATA_WIDTH-1:0] i_ext_wdata,
    output logic                  o_ext_gnt,
    output logic                  o_ext_rvalid,
    output logic [DATA_WIDTH-1:0] o_ext_rdata,
    output logic                  o_mem_we,
    output logic [1:0]            o_mem_store_type,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [3:0] c_cnt_init  = 4'(MEM_LATENCY - 1);

    logic [1:0]            r_state;
    logic                  r_last_ext;
    logic                  r_owner_ext;
    logic                  r_mem_we;
    logic [1:0]            r_store_type;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [3:0]            r_cnt;

    logic                  w_idle;
    logic                  w_cpu_win;
    logic                  w_cpu_gnt;
    logic                  w_ext_gnt;
    logic                  w_grant;
    logic                  w_sel_we;
    logic [1:0]            w_sel_store_type;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_idle    = (r_state == c_st_idle);
    // On a tie the requester that did not win last time takes the port.
    assign w_cpu_win = i_cpu_req & (~i_ext_req | r_last_ext);
    // Grants are gated by arstn so they drop the instant reset asserts.
    assign w_cpu_gnt = arstn & w_idle & w_cpu_win;
    assign w_ext_gnt = arstn & w_idle & i_ext_req & ~w_cpu_win;
    assign w_grant   = w_cpu_gnt | w_ext_gnt;

    assign w_sel_we         = w_ext_gnt ? i_ext_we         : i_cpu_we;
    assign w_sel_store_type = w_ext_gnt ? i_ext_store_type : i_cpu_store_type;
    assign w_sel_addr       = w_ext_gnt ? i_ext_addr       : i_cpu_addr;
    assign w_sel_wdata      = w_ext_gnt ? i_ext_wdata      : i_cpu_wdata;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state      <= c_st_idle;
            r_last_ext   <= 1'b1;
            r_owner_ext  <= 1'b0;
            r_mem_we     <= 1'b0;
            r_store_type <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_state      <= c_st_access;
                        r_owner_ext  <= w_ext_gnt;
                        r_last_ext   <= w_ext_gnt;
                        r_mem_we     <= w_sel_we;
                        r_store_type <= w_sel_store_type;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_cnt        <= c_cnt_init;
                    end
                end
                c_st_access: begin
                    // Writes capture rdata too; requesters simply ignore it.
                    if (r_cnt == 4'd0) begin
                        r_rdata <= i_mem_rdata;
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign o_cpu_gnt        = w_cpu_gnt;
    assign o_ext_gnt        = w_ext_gnt;
    assign o_cpu_rvalid     = (r_state == c_st_resp) & ~r_owner_ext;
    assign o_ext_rvalid     = (r_state == c_st_resp) & r_owner_ext;
    assign o_cpu_rdata      = r_rdata;
    assign o_ext_rdata      = r_rdata;
    assign o_mem_we         = r_mem_we;
    assign o_mem_store_type = r_store_type;
    assign o_mem_addr       = r_addr;
    assign o_mem_wdata      = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Randomized and directed bench for mem_arbiter with a transaction-level
// reference model feeding a response scoreboard.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        arstn;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [1:0]  cpu_st, ext_st, mem_st;
    logic [63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic        cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, mem_we;
    logic [63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [63:0] phys    [0:127];
    logic [63:0] ref_mem [0:127];

    typedef struct {
        logic        ext;
        logic        we;
        logic [63:0] rdata;
        int          due;
    } sb_t;
    sb_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .arstn(arstn),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_store_type(cpu_st),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_store_type(ext_st),
        .i_ext_addr(ext_addr), .i_ext_wdata(ext_wdata),
        .o_ext_gnt(ext_gnt), .o_ext_rvalid(ext_rvalid), .o_ext_rdata(ext_rdata),
        .o_mem_we(mem_we), .o_mem_store_type(mem_st), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    assign mem_rdata = phys[mem_addr[9:3]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory device: applies the write strobe mid-cycle.
    initial forever begin
        @(negedge clk);
        if (mem_we) phys[mem_addr[9:3]] = mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one transaction at a time, port free LAT+2 cycles after
    // a grant, ties go to whoever lost last, completion LAT+1 cycles later.
    initial begin
        int          busy_until;
        logic        last_ext;
        int          gcyc;
        logic        t_we;
        logic [1:0]  t_st;
        logic [63:0] t_addr, t_wdata;
        logic        exp_c, exp_e;
        sb_t         e;
        busy_until = 0; last_ext = 1'b1; gcyc = -100;
        t_we = 1'b0; t_st = '0; t_addr = '0; t_wdata = '0;
        forever begin
            @(negedge clk);
            if (!arstn) begin
                busy_until = 0; last_ext = 1'b1; gcyc = -100; t_we = 1'b0;
                sb.delete();
            end else begin
                exp_c = (cyc >= busy_until) && cpu_req && (!ext_req || last_ext);
                exp_e = (cyc >= busy_until) && ext_req && !exp_c;
                chk("cpu_gnt", {63'd0, cpu_gnt}, {63'd0, exp_c});
                chk("ext_gnt", {63'd0, ext_gnt}, {63'd0, exp_e});
                chk("mem_we", {63'd0, mem_we}, {63'd0, t_we && (cyc == gcyc + 1)});
                if (cyc > gcyc && cyc <= gcyc + LAT + 1) begin
                    chk("mem_addr", mem_addr, t_addr);
                    chk("mem_wdata", mem_wdata, t_wdata);
                    chk("mem_store_type", {62'd0, mem_st}, {62'd0, t_st});
                end
                if (exp_c || exp_e) begin
                    t_we    = exp_e ? ext_we    : cpu_we;
                    t_st    = exp_e ? ext_st    : cpu_st;
                    t_addr  = exp_e ? ext_addr  : cpu_addr;
                    t_wdata = exp_e ? ext_wdata : cpu_wdata;
                    e.ext   = exp_e;
                    e.we    = t_we;
                    e.rdata = ref_mem[t_addr[9:3]];
                    e.due   = cyc + LAT + 1;
                    sb.push_back(e);
                    if (t_we) ref_mem[t_addr[9:3]] = t_wdata;
                    busy_until = cyc + LAT + 2;
                    last_ext   = exp_e;
                    gcyc       = cyc;
                end
            end
        end
    end

    // Response monitor
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (arstn) begin
                if (cpu_rvalid || ext_rvalid) begin
                    chk("rvalid_onehot", {63'd0, cpu_rvalid && ext_rvalid}, 64'd0);
                    if (sb.size() == 0) begin
                        chk("unexpected_rvalid", {62'd0, cpu_rvalid, ext_rvalid}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rvalid_owner", {63'd0, ext_rvalid}, {63'd0, e.ext});
                        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
                        if (!e.we) chk("rdata", e.ext ? ext_rdata : cpu_rdata, e.rdata);
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    chk("missing_rvalid", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic set_req(input logic ext, input logic req, input logic we,
                           input logic [1:0] st, input logic [63:0] addr,
                           input logic [63:0] wdata);
        if (ext) begin
            ext_req = req; ext_we = we; ext_st = st; ext_addr = addr; ext_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_st = st; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    task automatic do_req(input logic ext, input logic we, input logic [1:0] st,
                          input logic [63:0] addr, input logic [63:0] wdata);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_req(ext, 1'b1, we, st, addr, wdata);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = ext ? ext_gnt : cpu_gnt;
        end
        if (!got) chk("gnt_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (ext) ext_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit gc, ge;
        for (int i = 0; i < 128; i++) begin
            phys[i]    = 64'hA5A5_0000_0000_0000 | (64'(i) * 64'h1111);
            ref_mem[i] = phys[i];
        end
        phys[32]    = 64'hDEAD;
        ref_mem[32] = 64'hDEAD;
        set_req(1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 64'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'b00, 64'h8, 64'h0);

        arstn = 1'b1;
        #2 arstn = 1'b0;
        #1;
        chk("rst_cpu_gnt", {63'd0, cpu_gnt}, 64'd0);
        chk("rst_ext_gnt", {63'd0, ext_gnt}, 64'd0);
        chk("rst_rvalid", {62'd0, cpu_rvalid, ext_rvalid}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_store_type", {62'd0, mem_st}, 64'd0);
        chk("rst_rdata", cpu_rdata, 64'd0);
        cpu_req = 1'b0; ext_req = 1'b0;
        repeat (3) @(posedge clk);
        #2 arstn = 1'b1;

        // Lone CPU read of the preloaded 0xDEAD location.
        do_req(1'b0, 1'b0, 2'b00, 64'h100, 64'h0);
        idle(6);

        // Both requesting continuously: grants alternate.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 2'b01, 64'h40, 64'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'b10, 64'h48, 64'h0);
        idle(14);
        cpu_req = 1'b0; ext_req = 1'b0;
        idle(6);

        // EXT write then CPU readback.
        do_req(1'b1, 1'b1, 2'b11, 64'h20, 64'h55);
        idle(5);
        do_req(1'b0, 1'b0, 2'b00, 64'h20, 64'h0);
        idle(5);

        // CPU request arriving while EXT owns the port.
        do_req(1'b1, 1'b0, 2'b00, 64'h30, 64'h0);
        do_req(1'b0, 1'b0, 2'b00, 64'h38, 64'h0);
        idle(6);

        // Reset during the ACCESS of a CPU write.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 2'b11, 64'h1F8, 64'h1234);
        @(negedge clk);
        chk("abort_setup_gnt", {63'd0, cpu_gnt}, 64'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        chk("abort_we_before", {63'd0, mem_we}, 64'd1);
        #1 arstn = 1'b0;
        #1;
        chk("abort_we_drop", {63'd0, mem_we}, 64'd0);
        chk("abort_rvalid", {62'd0, cpu_rvalid, ext_rvalid}, 64'd0);
        set_req(1'b0, 1'b1, 1'b0, 2'b00, 64'h10, 64'h0);
        set_req(1'b1, 1'b1, 1'b0, 2'b00, 64'h18, 64'h0);
        #1;
        chk("abort_gnt_gated", {62'd0, cpu_gnt, ext_gnt}, 64'd0);
        @(posedge clk); #2 arstn = 1'b1;
        @(negedge clk);
        chk("post_rst_tie_cpu", {62'd0, cpu_gnt, ext_gnt}, 64'd2);
        idle(6);
        cpu_req = 1'b0; ext_req = 1'b0;
        idle(8);

        // Randomized traffic: requests held until granted, fields churn freely.
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            gc = cpu_gnt; ge = ext_gnt;
            @(posedge clk); #1;
            if (!cpu_req || gc) cpu_req = ($urandom_range(0, 2) != 0);
            if (!ext_req || ge) ext_req = ($urandom_range(0, 2) != 0);
            cpu_we = $urandom_range(0, 1) == 1; cpu_st = 2'($urandom);
            cpu_addr = 64'($urandom_range(0, 31)) << 3; cpu_wdata = {$urandom, $urandom};
            ext_we = $urandom_range(0, 1) == 1; ext_st = 2'($urandom);
            ext_addr = 64'($urandom_range(0, 31)) << 3; ext_wdata = {$urandom, $urandom};
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        idle(LAT + 6);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  ADDR_WIDTH  64  memory address width
  DATA_WIDTH  64  memory data width
  MEM_LATENCY  2  cycles from address presented to read data valid; legal range 1..15
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
  clk  in  1  single clock, rising edge
  arstn  in  1  asynchronous active-low reset
  i_cpu_req  in  1  CPU access request
  i_cpu_we  in  1  CPU write (1) / read (0)
  i_cpu_store_type  in  2  store size code, passed to memory
  i_cpu_addr  in  ADDR_WIDTH  CPU address
  i_cpu_wdata  in  DATA_WIDTH  CPU write data
  o_cpu_gnt  out  1  CPU request accepted this cycle
  o_cpu_rvalid  out  1  CPU transaction complete; o_cpu_rdata valid
  o_cpu_rdata  out  DATA_WIDTH  CPU read data
  i_ext_req, i_ext_we, i_ext_store_type, i_ext_addr, i_ext_wdata  in  same widths as CPU  external (loader/DMA) requester
  o_ext_gnt, o_ext_rvalid, o_ext_rdata  out  same widths as CPU  external responses
  o_mem_we  out  1  memory write enable
  o_mem_store_type  out  2  store size to memory
  o_mem_addr  out  ADDR_WIDTH  memory address
  o_mem_wdata  out  DATA_WIDTH  memory write data
  i_mem_rdata  in  DATA_WIDTH  memory read data

Function
REQ-003 The block SHALL share one memory port between the CPU and EXT requesters, one transaction at a time.
REQ-004 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-005 In IDLE with any request high, o_*_gnt SHALL assert combinationally for exactly one requester.
REQ-006 With both requests high, the winner SHALL be the requester that did not win last; a lone requester SHALL always win.
REQ-007 At the granting edge, the block SHALL register we, store_type, addr, wdata and owner, set a counter to MEM_LATENCY-1, and enter ACCESS.
REQ-008 o_mem_addr, o_mem_wdata and o_mem_store_type SHALL be driven from the registered values and SHALL hold stable through ACCESS and RESP.
REQ-009 o_mem_we SHALL be 1 only in the first ACCESS cycle of a write, giving exactly one write edge per write transaction.
REQ-010 In ACCESS, the counter SHALL decrement each cycle; when it reaches 0, i_mem_rdata SHALL be captured into the read-data register and the FSM SHALL enter RESP.
REQ-011 In RESP, the owner's o_*_rvalid SHALL be 1 for exactly one cycle, for reads and for writes; the FSM SHALL then return to IDLE.
REQ-012 Latency from the gnt cycle to the rvalid cycle SHALL be MEM_LATENCY+1 cycles.
REQ-013 Sustained throughput SHALL be one transaction per MEM_LATENCY+2 cycles.
REQ-014 No gnt SHALL assert in ACCESS or RESP; pending requests SHALL wait, and requester inputs SHALL be ignored outside the gnt cycle.
REQ-015 o_cpu_rdata and o_ext_rdata SHALL both show the read-data register, meaningful only with the matching rvalid; the register SHALL hold between captures.
REQ-016 For a write transaction, the read-data register SHALL capture i_mem_rdata as for a read; requesters SHALL ignore rdata on write completion.
REQ-017 The last-winner flag SHALL update only at a granting edge.

Reset
REQ-018 arstn low SHALL immediately force: state IDLE; o_mem_we, all gnt and all rvalid 0; registered addr, wdata, store_type, rdata and counter 0; last winner EXT, so the CPU wins the first tie.
REQ-019 Reset during ACCESS or RESP SHALL abort the transaction with no rvalid and no further write edge.
REQ-020 After arstn deasserts, requests SHALL be granted from the first clk edge.

Verification
REQ-021 CPU read of 0x100 alone, MEM_LATENCY=2, memory returns 0xDEAD -> o_cpu_gnt at T0; o_mem_addr=0x100 at T1..T3; o_cpu_rvalid at T3 with o_cpu_rdata=0xDEAD.
REQ-022 Both requesters assert at T0 after reset and stay high -> CPU granted at T0, EXT granted at T4, CPU at T8; grants alternate with no starvation.
REQ-023 EXT write, addr 0x20, data 0x55, store_type 2'b11 -> o_mem_we=1 in exactly one cycle (T1) with those values; o_ext_rvalid at T3; memory readback of 0x20 returns 0x55.
REQ-024 CPU request rises during an EXT ACCESS -> no gnt until the FSM returns to IDLE; the CPU is granted in the first IDLE cycle.
REQ-025 arstn pulsed low during the ACCESS of a write -> o_mem_we drops asynchronously; no rvalid; state IDLE; next grant goes to the CPU on a tie.
REQ-026 MEM_LATENCY=1, back-to-back CPU reads -> gnt period of 3 cycles; rvalid 2 cycles after each gnt.
